multicycle_control: RTL and testbench

Multi-cycle control unit for the RV64 integer core. It sequences the shared datapath through fetch, decode, execute, memory and writeback for R-type, LW, SW and BEQ. It drives the mux selects, write strobes and ALU mode, and runs a single-port memory request/ready handshake used for both instruction and data accesses. It sits beside the immediate generator and register file and owns the PC, IR and register-file write enables.

---
 rtl/multicycle_control_if.sv | 30 +++
 rtl/multicycle_control.sv | 79 +++++++
 tb/tb_multicycle_control.sv | 139 +++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control-unit bundle between the multicycle controller and the shared datapath/memory.
interface multicycle_control_if #(parameter int CNTW = 64);
  logic [6:0] opcode;
  logic zero;
  logic mem_ready;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic ir_write;
  logic pc_write;
  logic pc_src;
  logic reg_write;
  logic mem_to_reg;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic illegal;
  logic [3:0] state;
  logic [CNTW-1:0] retired;
  modport master (
    input opcode, zero, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, mem_to_reg,
    output alu_src_a, alu_src_b, alu_op, illegal, state, retired
  );
  modport slave (
    output opcode, zero, mem_ready,
    input mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, mem_to_reg,
    input alu_src_a, alu_src_b, alu_op, illegal, state, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencing the shared RV64 datapath and memory handshake for R-type, LW, SW and BEQ.
module multicycle_control #(parameter int CNTW = 64) (
  input logic clk,
  input logic rst_n,
  multicycle_control_if.master bus
);
  typedef enum logic [3:0] {FETCH, DECODE, EXEC, ADDR, MEMRD, MEMWR, WBR, WBMEM, BRANCH, HALT} state_t;
  localparam logic [6:0] RT = 7'b0110011;
  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;
  localparam logic [6:0] BEQ = 7'b1100011;
  state_t st, nxt;
  logic req_q, we_q, iord_q, rw_q, m2r_q, pcs_q, ill_q;
  logic [1:0] a_q, b_q, op_q;
  logic [CNTW-1:0] cnt;
  logic retire;
  always_comb begin
    nxt = st;
    case (st)
      FETCH: nxt = bus.mem_ready ? DECODE : FETCH;
      DECODE: nxt = bus.opcode == RT ? EXEC :
                    (bus.opcode == LW || bus.opcode == SW) ? ADDR :
                    bus.opcode == BEQ ? BRANCH : HALT;
      EXEC: nxt = WBR;
      ADDR: nxt = bus.opcode == LW ? MEMRD : MEMWR;
      MEMRD: nxt = bus.mem_ready ? WBMEM : MEMRD;
      MEMWR: nxt = bus.mem_ready ? FETCH : MEMWR;
      WBR, WBMEM, BRANCH: nxt = FETCH;
      default: nxt = HALT;
    endcase
  end
  // Every path back into FETCH from another state completes an instruction.
  assign retire = (nxt == FETCH) && (st != FETCH);
  // Moore outputs are registered from the next state; reset values match FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= FETCH;
      cnt <= '0;
      ill_q <= 1'b0;
      req_q <= 1'b1;
      we_q <= 1'b0;
      iord_q <= 1'b0;
      rw_q <= 1'b0;
      m2r_q <= 1'b0;
      pcs_q <= 1'b0;
      a_q <= 2'b00;
      b_q <= 2'b01;
      op_q <= 2'b00;
    end else begin
      st <= nxt;
      cnt <= retire ? cnt + CNTW'(1) : cnt;
      ill_q <= ill_q | (nxt == HALT);
      req_q <= nxt inside {FETCH, MEMRD, MEMWR};
      we_q <= nxt == MEMWR;
      iord_q <= nxt inside {MEMRD, MEMWR};
      rw_q <= nxt inside {WBR, WBMEM};
      m2r_q <= nxt == WBMEM;
      pcs_q <= nxt == BRANCH;
      a_q <= nxt == DECODE ? 2'b10 : (nxt inside {EXEC, ADDR, BRANCH}) ? 2'b01 : 2'b00;
      b_q <= nxt == FETCH ? 2'b01 : (nxt inside {DECODE, ADDR}) ? 2'b10 : 2'b00;
      op_q <= nxt == EXEC ? 2'b10 : nxt == BRANCH ? 2'b01 : 2'b00;
    end
  end
  // Strobes are gated by rst_n so they drop the instant reset asserts.
  assign bus.mem_req = rst_n & req_q;
  assign bus.mem_we = rst_n & we_q;
  assign bus.ir_write = rst_n & (st == FETCH) & bus.mem_ready;
  assign bus.pc_write = rst_n & (((st == FETCH) & bus.mem_ready) | ((st == BRANCH) & bus.zero));
  assign bus.reg_write = rst_n & rw_q;
  assign bus.iord = iord_q;
  assign bus.mem_to_reg = m2r_q;
  assign bus.pc_src = pcs_q;
  assign bus.alu_src_a = a_q;
  assign bus.alu_src_b = b_q;
  assign bus.alu_op = op_q;
  assign bus.illegal = ill_q;
  assign bus.state = st;
  assign bus.retired = cnt;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed and randomized instruction traces checked cycle by cycle against a spec-level model.
`timescale 1ns/1ps
module tb_multicycle_control;
  localparam logic [6:0] RT = 7'b0110011;
  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] ADDI = 7'b0010011;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst4_n = 1'b0;
  int checks = 0;
  int errs = 0;
  logic [63:0] ret_exp = '0;
  multicycle_control_if #(.CNTW(64)) bus ();
  multicycle_control_if #(.CNTW(4)) bus4 ();
  multicycle_control #(.CNTW(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  multicycle_control #(.CNTW(4)) dut4 (.clk(clk), .rst_n(rst4_n), .bus(bus4));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [14:0] expv(input int s, input bit r, input bit z);
    logic req = 0, we = 0, io = 0, irw = 0, pcw = 0, pcs = 0, rw = 0, m2r = 0, il = 0;
    logic [1:0] a = 0, b = 0, op = 0;
    case (s)
      0: begin req = 1; b = 2'b01; irw = r; pcw = r; end
      1: begin a = 2'b10; b = 2'b10; end
      2: begin a = 2'b01; op = 2'b10; end
      3: begin a = 2'b01; b = 2'b10; end
      4: begin req = 1; io = 1; end
      5: begin req = 1; we = 1; io = 1; end
      6: rw = 1;
      7: begin rw = 1; m2r = 1; end
      8: begin a = 2'b01; op = 2'b01; pcs = 1; pcw = z; end
      default: il = 1;
    endcase
    return {req, we, io, irw, pcw, pcs, rw, m2r, a, b, op, il};
  endfunction
  function automatic logic [14:0] obsv();
    return {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write, bus.pc_src,
            bus.reg_write, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.illegal};
  endfunction
  task automatic step(input int s, input bit r);
    @(negedge clk);
    bus.mem_ready = r;
    #1;
    chk("state", 64'(bus.state), 64'(s));
    chk($sformatf("outs_s%0d", s), 64'(obsv()), 64'(expv(s, r, bus.zero)));
    chk("retired", bus.retired, ret_exp);
  endtask
  function automatic bit rb();
    return 1'($urandom % 2);
  endfunction
  task automatic instr(input logic [6:0] op, input int wf, input int wm, input bit z);
    bus.opcode = op;
    bus.zero = z;
    repeat (wf) step(0, 1'b0);
    step(0, 1'b1);
    step(1, rb());
    case (op)
      RT: begin step(2, rb()); step(6, rb()); end
      LW: begin step(3, rb()); repeat (wm) step(4, 1'b0); step(4, 1'b1); step(7, rb()); end
      SW: begin step(3, rb()); repeat (wm) step(5, 1'b0); step(5, 1'b1); end
      BEQ: step(8, rb());
      default: begin repeat (4) step(9, rb()); return; end
    endcase
    ret_exp++;
  endtask
  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    ret_exp = '0;
    chk("rst_state", 64'(bus.state), 64'd0);
    chk("rst_strobes", 64'({bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.reg_write}), 64'd0);
    chk("rst_illegal", 64'(bus.illegal), 64'd0);
    chk("rst_retired", bus.retired, ret_exp);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("first_req", 64'(bus.mem_req), 64'd1);
  endtask
  initial begin
    logic [6:0] ops [4];
    ops[0] = RT; ops[1] = LW; ops[2] = SW; ops[3] = BEQ;
    bus.opcode = RT;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    bus4.opcode = BEQ;
    bus4.zero = 1'b0;
    bus4.mem_ready = 1'b1;
    reset_pulse();
    instr(RT, 0, 0, 1'b0);
    instr(LW, 0, 2, 1'b0);
    instr(SW, 1, 0, 1'b1);
    instr(BEQ, 0, 0, 1'b1);
    instr(BEQ, 2, 0, 1'b0);
    for (int i = 0; i < 30; i++)
      instr(ops[$urandom_range(0, 3)], $urandom_range(0, 3), $urandom_range(0, 3), rb());
    // Reset while MEMRD waits: request must vanish without retiring.
    bus.opcode = LW;
    step(0, 1'b1);
    step(1, 1'b0);
    step(3, 1'b0);
    step(4, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    ret_exp = '0;
    chk("midrst_req", 64'(bus.mem_req), 64'd0);
    chk("midrst_state", 64'(bus.state), 64'd0);
    chk("midrst_retired", bus.retired, ret_exp);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_first_req", 64'(bus.mem_req), 64'd1);
    instr(SW, 0, 1, 1'b0);
    instr(ADDI, 0, 0, 1'b0);
    reset_pulse();
    instr(RT, 1, 0, 1'b0);
    instr(BEQ, 0, 0, 1'b1);
    @(negedge clk);
    rst4_n = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      chk("wrap4", 64'(bus4.retired), 64'((c / 3) % 16));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
